onehot_stopwatch_src: RTL
=========================

Name: onehot_stopwatch_src

Overview:
- Produces the two 21-bit one-hot value buses, timer_out and count_out, that feed the seven-segment display driver.
- Bit position i set means value i, with a range of 0..20.
- Debounces two raw board buttons.
- Runs a 20-step session timer from a clock prescaler and counts debounced count-button presses while the session runs.
- Sits between the board buttons and the display driver in the LED display control top level.

Parameters:
TICK_CYCLES, 100_000_000, clk cycles per timer step (1 s at 100 MHz); must be >= 2
DEBOUNCE_CYCLES, 2_000_000, cycles a synchronized button level must stay stable before it is accepted (20 ms); must be >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
start_btn  input  1  raw asynchronous start/restart button, active-high
count_btn  input  1  raw asynchronous count button, active-high
timer_out  output  21  one-hot elapsed-step value, bit i = i steps
count_out  output  21  one-hot press count, bit i = i presses
running  output  1  high while in RUN
done  output  1  high while in DONE

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. No other clocks or resets.
- Reset values: timer_out = 21'h000001, count_out = 21'h000001, running = 0, done = 0, state = IDLE.
  - Reset also sets prescaler = 0, both debounce counters = 0, debounced levels = 0, synchronizers = 0.
  - Reset asserted mid-session returns to these values on the next edge; no partial state survives.
- Input path, per button:
  - 2-FF synchronizer.
  - Debounce counter: cleared whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronized level and the counter clears.
  - A rising edge of the debounced level gives a 1-cycle pulse: start_p or count_p.
  - Pulse latency from a clean raw edge is 2 + DEBOUNCE_CYCLES + 1 cycles. A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
  - One held press produces exactly one pulse.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 only in RUN, then wraps to 0.
  - tick = 1 in the cycle the prescaler equals TICK_CYCLES-1.
  - The prescaler is held at 0 outside RUN.
- FSM:
  - IDLE: start_p loads timer_out = 1 and count_out = 1, clears the prescaler, and goes to RUN. count_p is ignored.
  - RUN:
    - tick: timer_out <= timer_out << 1.
    - If the pre-shift timer_out[19] = 1 (value becomes 20), go to DONE.
    - count_p: count_out <= count_out << 1, unless count_out[20] = 1; it saturates at 20 and never wraps.
    - start_p is ignored in RUN.
  - DONE: timer_out holds bit 20 and count_out holds. count_p is ignored. start_p reloads both buses to 1, clears the prescaler, and goes to RUN.
- Simultaneous events:
  - tick and count_p in the same RUN cycle: both apply, including the cycle that enters DONE (that press is counted).
  - start_p and count_p in the same IDLE/DONE cycle: the restart wins and count_out = 1.
- Outputs are registered; running = (state==RUN) and done = (state==DONE) are registered with the state.
- Invariant: timer_out and count_out each have exactly one bit set in every cycle after reset.

Test Plan:
(Bench uses TICK_CYCLES=10, DEBOUNCE_CYCLES=4.)
1. Reset: hold rst 3 cycles -> timer_out = 21'h000001, count_out = 21'h000001, running = 0, done = 0; asserting rst during RUN returns the same values next edge.
2. Start and timing: clean start_btn press -> running rises 2+4+1+1 cycles after the raw edge. timer_out = 21'h000002 exactly 10 cycles later, 21'h000004 after 20. done = 1 with timer_out = 21'h100000 after 200 cycles of RUN.
3. Count and saturation: 3 clean presses in RUN -> count_out = 21'h000008. 25 presses -> count_out = 21'h100000, never wraps. Presses in IDLE/DONE leave count_out unchanged.
4. Debounce: count_btn glitches of 1..3 cycles -> no change. One press held 1000 cycles -> exactly +1. Bouncy edge (toggling every cycle for 3 cycles, then stable) -> exactly +1.
5. Simultaneity and restart:
   - Force count_p on the final tick cycle -> DONE entered and the count increments.
   - start_p in DONE -> timer_out = count_out = 21'h000001, running = 1.
   - start_p in RUN -> no effect.
6. Invariant: random button stimulus over 100k cycles -> a one-hot check on both buses never fails.

Source files
------------

// File: rtl/onehot_stopwatch_src.sv
// rtl/onehot_stopwatch_src.sv - debounced stopwatch driving two one-hot display value buses
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start_btn  raw start/restart button (asynchronous, active-high)
//   count_btn  raw count button (asynchronous, active-high)
//   timer_out  one-hot elapsed step value, bit i = i steps (0..20)
//   count_out  one-hot press count, bit i = i presses (0..20, saturating)
//   running    high while a session is timing
//   done       high once the session has reached 20 steps
module onehot_stopwatch_src #(
  parameter int unsigned TICK_CYCLES     = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        count_btn,
  output logic [20:0] timer_out,
  output logic [20:0] count_out,
  output logic        running,
  output logic        done
);

  localparam int unsigned TW = $clog2(TICK_CYCLES);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Button lanes: index 0 = start, index 1 = count.
  logic [1:0]    btn;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_prev_q, pulse_q;
  logic [DW-1:0] dcnt_q [2];

  assign btn = {count_btn, start_btn};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      pulse_q    <= '0;
      for (int i = 0; i < 2; i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      // Registered rising-edge detect so the pulse is a clean flop output.
      pulse_q    <= deb_q & ~deb_prev_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[i]  <= sync2_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic start_p, count_p;
  assign start_p = pulse_q[0];
  assign count_p = pulse_q[1];

  state_t        state_q, state_d;
  logic [TW-1:0] presc_q, presc_d;
  logic [20:0]   timer_q, timer_d;
  logic [20:0]   count_q, count_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          tick;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    presc_d = '0;
    tick    = (state_q == RUN) && (presc_q == TW'(TICK_CYCLES - 1));
    case (state_q)
      RUN: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          timer_d = timer_q << 1;
          if (timer_q[19]) state_d = DONE;
        end
        // A press landing on the final tick still counts.
        if (count_p && !count_q[20]) count_d = count_q << 1;
      end
      default: begin
        // IDLE and DONE: restart wins over a simultaneous count press.
        if (start_p) begin
          timer_d = 21'd1;
          count_d = 21'd1;
          state_d = RUN;
        end
      end
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      timer_q   <= 21'd1;
      count_q   <= 21'd1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign timer_out = timer_q;
  assign count_out = count_q;
  assign running   = running_q;
  assign done      = done_q;

endmodule
